reg_display_ctrl: RTL

- Downstream consumer of the processor's register-read display output (32-bit value of the register selected by the board switches).
- Converts the value to six 7-segment digit codes for the DE1_SoC HEX5..HEX0 displays.
- Two modes: unsigned decimal via sequential double-dabble, or hexadecimal (low 24 bits).
- Display always shows a coherent snapshot. Outputs never show a half-converted value.

---
 rtl/reg_display_ctrl.sv | 194 +++++++++++++++++++
 1 files changed

// File: rtl/reg_display_ctrl.sv
// reg_display_ctrl: turns the processor's register-read value into six
// active-low 7-segment codes for HEX5..HEX0. Decimal mode uses a sequential
// double-dabble converter. Hex mode shows the low 24 bits. The outputs only
// change in COMMIT, so the display never shows a partly converted value.
module reg_display_ctrl #(
    parameter logic LZ_BLANK = 1'b1,
    parameter logic OVF_DASH = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] value,
    input  logic        dec_mode,
    output logic [6:0]  hex0,
    output logic [6:0]  hex1,
    output logic [6:0]  hex2,
    output logic [6:0]  hex3,
    output logic [6:0]  hex4,
    output logic [6:0]  hex5,
    output logic        busy,
    output logic        ovf
);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        COMMIT
    } state_t;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;

    state_t            r_state;
    state_t            w_next_state;
    logic              r_first;
    logic [31:0]       r_shown_value;
    logic              r_shown_mode;
    logic [31:0]       r_cap_value;
    logic              r_cap_mode;
    logic [39:0]       r_bcd;
    logic [31:0]       r_shift;
    logic [4:0]        r_cnt;
    logic [5:0][6:0]   r_hex;
    logic              r_ovf;

    logic              w_start;
    logic [39:0]       w_adj;
    logic [39:0]       w_bcd_next;
    logic [31:0]       w_shift_next;
    logic              w_dec_ovf;
    logic              w_zero_run;
    logic [5:0]        w_blank;
    logic [5:0][6:0]   w_commit_hex;
    logic              w_commit_ovf;

    // Active-low segment pattern {g,f,e,d,c,b,a} for one hex/BCD nibble.
    function automatic logic [6:0] segCode(input logic [3:0] nib);
        logic [6:0] seg;
        case (nib)
            4'h0:    seg = 7'b1000000;
            4'h1:    seg = 7'b1111001;
            4'h2:    seg = 7'b0100100;
            4'h3:    seg = 7'b0110000;
            4'h4:    seg = 7'b0011001;
            4'h5:    seg = 7'b0010010;
            4'h6:    seg = 7'b0000010;
            4'h7:    seg = 7'b1111000;
            4'h8:    seg = 7'b0000000;
            4'h9:    seg = 7'b0010000;
            4'hA:    seg = 7'b0001000;
            4'hB:    seg = 7'b0000011;
            4'hC:    seg = 7'b1000110;
            4'hD:    seg = 7'b0100001;
            4'hE:    seg = 7'b0000110;
            default: seg = 7'b0001110;
        endcase
        return seg;
    endfunction

    // A new conversion is needed on power-up or whenever the inputs differ
    // from what is currently shown.
    assign w_start = r_first || (value != r_shown_value) || (dec_mode != r_shown_mode);

    // One double-dabble step: add 3 to every nibble >= 5, then shift the
    // combined {bcd, shift} register left by one.
    always_comb begin
        w_adj = r_bcd;
        for (int i = 0; i < 10; i++) begin
            if (r_bcd[4*i +: 4] >= 4'd5) begin
                w_adj[4*i +: 4] = r_bcd[4*i +: 4] + 4'd3;
            end
        end
        w_bcd_next   = {w_adj[38:0], r_shift[31]};
        w_shift_next = {r_shift[30:0], 1'b0};
    end

    // Build the six digit codes and the overflow flag that COMMIT will load.
    // Leading-zero blanking is off on overflow, where the hidden upper
    // digits make the shown zeros significant.
    always_comb begin
        w_dec_ovf    = |r_bcd[39:24];
        w_zero_run   = 1'b1;
        w_blank      = '0;
        w_commit_hex = '0;
        for (int k = 5; k >= 0; k--) begin
            w_zero_run = w_zero_run && (r_bcd[4*k +: 4] == 4'd0);
            w_blank[k] = LZ_BLANK && !w_dec_ovf && (k >= 1) && w_zero_run;
        end
        for (int k = 0; k < 6; k++) begin
            if (!r_cap_mode) begin
                w_commit_hex[k] = segCode(r_cap_value[4*k +: 4]);
            end else if (w_dec_ovf && OVF_DASH) begin
                w_commit_hex[k] = SEG_DASH;
            end else if (w_blank[k]) begin
                w_commit_hex[k] = SEG_BLANK;
            end else begin
                w_commit_hex[k] = segCode(r_bcd[4*k +: 4]);
            end
        end
        w_commit_ovf = r_cap_mode && w_dec_ovf;
    end

    // Next-state logic: IDLE waits for a change, SHIFT runs 32 steps,
    // COMMIT updates the display for one cycle.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: begin
                if (w_start) begin
                    w_next_state = dec_mode ? SHIFT : COMMIT;
                end
            end
            SHIFT: begin
                if (r_cnt == 5'd31) begin
                    w_next_state = COMMIT;
                end
            end
            COMMIT:  w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    // State, capture, converter and display registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state       <= IDLE;
            r_first       <= 1'b1;
            r_shown_value <= '0;
            r_shown_mode  <= 1'b0;
            r_cap_value   <= '0;
            r_cap_mode    <= 1'b0;
            r_bcd         <= '0;
            r_shift       <= '0;
            r_cnt         <= '0;
            r_hex         <= {6{SEG_BLANK}};
            r_ovf         <= 1'b0;
        end else begin
            r_state <= w_next_state;
            case (r_state)
                IDLE: begin
                    if (w_start) begin
                        r_cap_value <= value;
                        r_cap_mode  <= dec_mode;
                        r_shift     <= value;
                        r_bcd       <= '0;
                        r_cnt       <= '0;
                    end
                end
                SHIFT: begin
                    r_bcd   <= w_bcd_next;
                    r_shift <= w_shift_next;
                    r_cnt   <= r_cnt + 5'd1;
                end
                COMMIT: begin
                    r_hex         <= w_commit_hex;
                    r_ovf         <= w_commit_ovf;
                    r_shown_value <= r_cap_value;
                    r_shown_mode  <= r_cap_mode;
                    r_first       <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign hex0 = r_hex[0];
    assign hex1 = r_hex[1];
    assign hex2 = r_hex[2];
    assign hex3 = r_hex[3];
    assign hex4 = r_hex[4];
    assign hex5 = r_hex[5];
    assign busy = (r_state != IDLE);
    assign ovf  = r_ovf;

endmodule
